// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue: fetches 32-bit words ahead of the PC into a small FIFO
// and realigns them into 16-bit compressed or 32-bit instructions for the IF stage.
module prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} FetchState;

  FetchState     r_state, w_stateNext;
  logic [31:0]   r_addr, w_addrNext;
  logic [31:0]   r_pendAddr, w_pendAddrNext;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rdPtr, r_wrPtr;
  logic [AW:0]   r_count;
  logic          r_hwOff;
  logic [31:0]   r_pc;

  logic [31:0] w_head, w_flushWord, w_flushPc;
  logic [15:0] w_lo, w_nextLo;
  logic        w_isC, w_valid, w_consume, w_push, w_pop;

  assign w_flushWord = flush_pc_i & 32'hFFFF_FFFC;
  assign w_flushPc   = flush_pc_i & 32'hFFFF_FFFE;

  assign w_head    = r_mem[r_rdPtr];
  assign w_nextLo  = r_mem[r_rdPtr + PTR_ONE][15:0];
  assign w_lo      = r_hwOff ? w_head[31:16] : w_head[15:0];
  assign w_isC     = (w_lo[1:0] != 2'b11);
  // A 32-bit instruction starting in the upper half needs the following word too.
  assign w_valid   = (r_count != '0) && (w_isC || !r_hwOff || (r_count >= CNT_TWO));
  assign w_consume = w_valid && instr_ready_i;
  assign w_pop     = w_consume && (!w_isC || r_hwOff);
  assign w_push    = (r_state == REQ) && ack_i && !flush_i;

  assign req_o         = (r_state == REQ) || (r_state == DISCARD);
  assign addr_o        = r_addr;
  assign instr_valid_o = w_valid;
  assign instr_pc_o    = r_pc;
  assign instr_is_c_o  = w_isC;

  always_comb begin
    instr_o = w_head;
    if (w_isC)
      instr_o = {16'h0000, w_lo};
    else if (r_hwOff)
      instr_o = {w_nextLo, w_head[31:16]};
  end

  always_comb begin
    w_stateNext    = r_state;
    w_addrNext     = r_addr;
    w_pendAddrNext = r_pendAddr;
    case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_addrNext  = w_flushWord;
          w_stateNext = REQ;
        end else if (r_count != CNT_FULL) begin
          w_stateNext = REQ;
        end
      end
      REQ: begin
        if (ack_i) begin
          if (flush_i) begin
            w_addrNext = w_flushWord;
          end else begin
            w_addrNext  = r_addr + 32'd4;
            w_stateNext = IDLE;
          end
        end else if (flush_i) begin
          w_pendAddrNext = w_flushWord;
          w_stateNext    = DISCARD;
        end
      end
      DISCARD: begin
        // The outstanding response belongs to the old stream and is dropped.
        if (ack_i) begin
          w_addrNext  = flush_i ? w_flushWord : r_pendAddr;
          w_stateNext = REQ;
        end else if (flush_i) begin
          w_pendAddrNext = w_flushWord;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= RESET_PC & 32'hFFFF_FFFC;
      r_pendAddr <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      r_state    <= w_stateNext;
      r_addr     <= w_addrNext;
      r_pendAddr <= w_pendAddrNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_hwOff <= 1'b0;
      r_pc    <= RESET_PC;
    end else if (flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_hwOff <= flush_pc_i[1];
      r_pc    <= w_flushPc;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)
        r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_push && !w_pop)
        r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_ONE;
      if (w_consume) begin
        r_pc <= r_pc + (w_isC ? 32'd2 : 32'd4);
        if (w_isC)
          r_hwOff <= !r_hwOff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wrPtr] <= rdata_i;
  end

endmodule
